// File: rtl/text_terminal_controller.sv
// rtl/text_terminal_controller.sv - UART byte stream to character RAM write sequencer for the VGA text terminal
// Optional last-row scrolling is enabled by defining TERMINAL_SCROLL_EN.
module text_terminal_controller #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter int          ADDR_WIDTH = 12,
    parameter logic [7:0]  BLANK      = 8'h20
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [7:0]            Data_i,
    input  logic                  DataValid_i,
    output logic                  Busy_o,
    output logic                  Overflow_o,
    output logic                  WriteEnable_o,
    output logic [ADDR_WIDTH-1:0] WriteAddress_o,
    output logic [7:0]            WriteData_o,
    output logic [2:0]            Color_o,
    output logic                  ColorWrite_o,
    output logic [6:0]            CursorX_o,
    output logic [4:0]            CursorY_o,
    output logic [4:0]            RowOffset_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_ROWCLR} state_t;

    localparam logic [6:0]            X_LAST  = 7'(COLS - 1);
    localparam logic [4:0]            Y_LAST  = 5'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] COLS_W  = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] CELLS_W = ADDR_WIDTH'(COLS * ROWS);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [6:0]              x_q, x_d;
    logic [4:0]              y_q, y_d;
    logic [4:0]              off_q, off_d;
    logic [2:0]              color_q, color_d;
    logic                    color_wr_q, color_wr_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    lf_req;

    // Logical row plus scroll offset wraps at ROWS, not at the power of two.
    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [4:0] y,
                                                        input logic [4:0] off,
                                                        input logic [6:0] x);
        logic [5:0] row;
        row = {1'b0, y} + {1'b0, off};
        if (row >= 6'(ROWS))
            row = row - 6'(ROWS);
        return ADDR_WIDTH'(row) * COLS_W + ADDR_WIDTH'(x);
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            off_q      <= '0;
            color_q    <= 3'b111;
            color_wr_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            base_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            off_q      <= off_d;
            color_q    <= color_d;
            color_wr_q <= color_wr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        off_d      = off_q;
        color_d    = color_q;
        color_wr_d = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        lf_req     = 1'b0;

        if (DataValid_i && busy_q)
            ovf_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (DataValid_i) begin
                    if (Data_i < 8'h08) begin
                        color_d    = Data_i[2:0];
                        color_wr_d = 1'b1;
                    end else begin
                        case (Data_i)
                            8'h08: begin
                                if (x_q != 7'd0) begin
                                    x_d    = x_q - 7'd1;
                                    we_d   = 1'b1;
                                    addr_d = cell_addr(y_q, off_q, x_q - 7'd1);
                                    data_d = BLANK;
                                end
                            end
                            8'h0A: lf_req = 1'b1;
                            8'h0D: x_d = '0;
                            8'h0C: begin
                                x_d     = '0;
                                y_d     = '0;
                                off_d   = '0;
                                state_d = ST_CLEAR;
                                busy_d  = 1'b1;
                                we_d    = 1'b1;
                                addr_d  = '0;
                                data_d  = BLANK;
                                cnt_d   = CNT_ONE;
                            end
                            8'h1B: begin
                                x_d = '0;
                                y_d = '0;
                            end
                            default: begin
                                we_d   = 1'b1;
                                addr_d = cell_addr(y_q, off_q, x_q);
                                data_d = Data_i;
                                if (x_q == X_LAST) begin
                                    x_d    = '0;
                                    lf_req = 1'b1;
                                end else begin
                                    x_d = x_q + 7'd1;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CELLS_W) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = BLANK;
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            ST_ROWCLR: begin
                if (cnt_q == COLS_W) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    we_d   = 1'b1;
                    addr_d = base_q + cnt_q;
                    data_d = BLANK;
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (lf_req) begin
            if (y_q != Y_LAST) begin
                y_d = y_q + 5'd1;
            end else begin
`ifdef TERMINAL_SCROLL_EN
                // The old top physical row becomes the new bottom row; a character
                // written this cycle delays the first blank by one cycle.
                off_d   = (off_q == Y_LAST) ? 5'd0 : off_q + 5'd1;
                state_d = ST_ROWCLR;
                busy_d  = 1'b1;
                base_d  = ADDR_WIDTH'(off_q) * COLS_W;
                if (we_d) begin
                    cnt_d = '0;
                end else begin
                    we_d   = 1'b1;
                    addr_d = ADDR_WIDTH'(off_q) * COLS_W;
                    data_d = BLANK;
                    cnt_d  = CNT_ONE;
                end
`else
                y_d = '0;
`endif
            end
        end
    end

    assign Busy_o         = busy_q;
    assign Overflow_o     = ovf_q;
    assign WriteEnable_o  = we_q;
    assign WriteAddress_o = addr_q;
    assign WriteData_o    = data_q;
    assign Color_o        = color_q;
    assign ColorWrite_o   = color_wr_q;
    assign CursorX_o      = x_q;
    assign CursorY_o      = y_q;
    assign RowOffset_o    = off_q;

endmodule
